// File: rtl/multiword_add_seq.sv
// ---------------------------------------------------------------------------
// multiword_add_seq
//
// Sequential multi-word adder. A WIDTH-bit add (WIDTH = CHUNK_W*NUM_CHUNKS)
// is performed by one CHUNK_W-bit carry-lookahead slice reused over
// NUM_CHUNKS consecutive cycles. The chunk-to-chunk carry lives in carry_reg.
//
// Optional feature macro: MWADD_SUB_EN adds the `sub` port. With sub=1 on
// the accepting edge the result is a - b (B inverted, initial carry 1).
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   request; accepted in IDLE or DONE
//   a, b   in   WIDTH-bit operands, sampled on the accepting edge
//   Cin    in   carry into chunk 0, sampled on the accepting edge
//   sub    in   subtract request (MWADD_SUB_EN only)
//   busy   out  chunks being processed
//   done   out  one-cycle pulse, result valid
//   sum    out  WIDTH-bit result register
//   carry  out  carry-out of the MSB chunk
//   ovf    out  signed overflow (carry into MSB ^ carry out)
// ---------------------------------------------------------------------------
module multiword_add_seq #(
    parameter int CHUNK_W    = 8,
    parameter int NUM_CHUNKS = 4,
    localparam int WIDTH     = CHUNK_W * NUM_CHUNKS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin,
`ifdef MWADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic             carry_reg;
    logic [WIDTH-1:0] a_q, b_q;

    // Operand conditioning at accept time: subtract is a + ~b + 1.
    logic [WIDTH-1:0] b_in;
    logic             c_in;
`ifdef MWADD_SUB_EN
    assign b_in = sub ? ~b : b;
    assign c_in = sub ? 1'b1 : Cin;
`else
    assign b_in = b;
    assign c_in = Cin;
`endif

    // ---------------- lookahead slice for chunk idx ----------------
    logic [CHUNK_W-1:0] ca, cb, g, p, gg, pp, cbit, csum;
    logic               cout;

    always_comb begin
        ca = a_q[idx*CHUNK_W +: CHUNK_W];
        cb = b_q[idx*CHUNK_W +: CHUNK_W];
        g  = ca & cb;
        p  = ca ^ cb;
        // Group generate/propagate from bit 0 up to bit i.
        gg[0] = g[0];
        pp[0] = p[0];
        for (int i = 1; i < CHUNK_W; i++) begin
            gg[i] = g[i] | (p[i] & gg[i-1]);
            pp[i] = p[i] & pp[i-1];
        end
        // Carry into each bit is resolved directly from the group terms and
        // the chunk carry-in, never rippled bit by bit.
        cbit[0] = carry_reg;
        for (int i = 1; i < CHUNK_W; i++)
            cbit[i] = gg[i-1] | (pp[i-1] & carry_reg);
        cout = gg[CHUNK_W-1] | (pp[CHUNK_W-1] & carry_reg);
        csum = p ^ cbit;
    end

    // ---------------- control / result registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            carry_reg <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q       <= a;
                        b_q       <= b_in;
                        carry_reg <= c_in;
                        idx       <= '0;
                        sum       <= '0;
                        carry     <= 1'b0;
                        ovf       <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    sum[idx*CHUNK_W +: CHUNK_W] <= csum;
                    carry_reg <= cout;
                    if (idx == LAST_IDX) begin
                        // idx stays on the last chunk; reset at next accept.
                        carry <= cout;
                        ovf   <= cbit[CHUNK_W-1] ^ cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
module tb_multiword_add_seq;

    localparam int CHUNK_W    = 8;
    localparam int NUM_CHUNKS = 4;
    localparam int WIDTH      = CHUNK_W * NUM_CHUNKS;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0, b = '0;
    logic             Cin = 1'b0;
`ifdef MWADD_SUB_EN
    logic             sub = 1'b0;
`endif
    logic             busy, done, carry, ovf;
    logic [WIDTH-1:0] sum;

    multiword_add_seq #(.CHUNK_W(CHUNK_W), .NUM_CHUNKS(NUM_CHUNKS)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .Cin(Cin),
`ifdef MWADD_SUB_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .sum(sum), .carry(carry), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    // Scoreboard monitor: every done pulse consumes one expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sum",   64'(sum),   64'(e.sum));
                    chk("carry", 64'(carry), 64'(e.carry));
                    chk("ovf",   64'(ovf),   64'(e.ovf));
                end
            end
        end
    end

    // Drive a request at the current negedge; accepted on the next posedge.
    task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic ic, input logic is,
                         input logic [WIDTH-1:0] es, input logic ec, input logic eo,
                         input bit push);
        exp_t e;
        start = 1'b1; a = ia; b = ib; Cin = ic;
`ifdef MWADD_SUB_EN
        sub = is;
`else
        if (is) $display("note: sub request ignored in add-only build");
`endif
        e.sum = es; e.carry = ec; e.ovf = eo;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom; b = $urandom; Cin = 1'b0;
    endtask

    // Checks busy for NUM_CHUNKS cycles, then the done cycle. Returns at the
    // done-cycle negedge so a back-to-back request can be driven there.
    task automatic timing(input string tag);
        for (int k = 0; k < NUM_CHUNKS; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk({tag, "_clr_sum"}, 64'(sum), 64'd0);
                chk({tag, "_clr_cy"},  64'({carry, ovf}), 64'd0);
            end
            chk({tag, "_busy"}, 64'({busy, done}), 64'b10);
        end
        @(negedge clk);
        chk({tag, "_done"}, 64'({busy, done}), 64'b01);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_outs", 64'({busy, done, carry, ovf}), 64'd0);
        chk("rst_sum",  64'(sum), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors
        issue(32'h00000001, 32'h00000002, 1'b0, 1'b0, 32'h00000003, 1'b0, 1'b0, 1); timing("t1");
        @(negedge clk);
        chk("t1_idle", 64'({busy, done}), 64'd0);
        chk("t1_hold", 64'(sum), 64'h3);
        issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1); timing("t2");
        @(negedge clk);
        issue(32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b1, 1); timing("t3");
        @(negedge clk);
        issue(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1); timing("t3b");
        @(negedge clk);
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1); timing("t3c");
        @(negedge clk);

        // Start during RUN is ignored
        issue(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1);
        @(negedge clk);
        start = 1'b1; a = 32'h11; b = 32'h22;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk); @(negedge clk);
        @(negedge clk);
        chk("t4a_done", 64'({busy, done}), 64'b01);
        // Back-to-back from DONE, no IDLE gap
        issue(32'h00000010, 32'h00000020, 1'b0, 1'b0, 32'h00000030, 1'b0, 1'b0, 1);
        timing("t4b");
        @(negedge clk);

        // Reset mid-RUN: aborted op must never signal done
        issue(32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, '0, 1'b0, 1'b0, 0);
        @(negedge clk);
        chk("t5_busy", 64'(busy), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_rst_outs", 64'({busy, done, carry}), 64'd0);
        chk("t5_rst_sum",  64'(sum), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        issue(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 1); timing("t5");
        @(negedge clk);

`ifdef MWADD_SUB_EN
        issue(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1); timing("s1");
        @(negedge clk);
        issue(32'd7, 32'd5, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0, 1); timing("s2");
        @(negedge clk);
        issue(32'h80000000, 32'd1, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1); timing("s3");
        @(negedge clk);
`endif

        repeat (4) @(negedge clk);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global safety bound
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
